// File: rtl/program_loader.sv
// Program image loader: accepts a length-prefixed, checksummed byte stream into a
// small instruction store and holds the CPU core in reset until a good image lands.
module program_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   byte_count
);

  // Handshake: a byte moves on a rising edge only when in_valid && in_ready;
  // in_ready depends on state alone, never on in_valid.
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_LOAD,
    S_CHK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t state;
  state_t state_next;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   len;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] sum;
  logic [ADDR_W:0]   count;

  logic              xfer;
  logic              restart;
  logic              len_ok;
  logic              last_byte;
  logic [DATA_W-1:0] sum_chk;

  assign in_ready   = (state == S_LEN) || (state == S_LOAD) || (state == S_CHK);
  assign xfer       = in_valid && in_ready;
  assign restart    = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
  assign len_ok     = (in_data != '0) && (in_data <= DATA_W'(DEPTH));
  assign last_byte  = ({1'b0, idx} == (len - (ADDR_W+1)'(1)));
  assign sum_chk    = sum + in_data;

  // Status flags are decodes of the registered state, so they change on the
  // same edge that moves the FSM.
  assign cpu_reset  = (state != S_DONE);
  assign load_done  = (state == S_DONE);
  assign load_error = (state == S_ERROR);
  assign byte_count = count;
  assign fetch_data = mem[fetch_addr];

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_LEN;
      S_LEN:   if (xfer) state_next = len_ok ? S_LOAD : S_ERROR;
      S_LOAD:  if (xfer && last_byte) state_next = S_CHK;
      S_CHK:   if (xfer) state_next = (sum_chk == '0) ? S_DONE : S_ERROR;
      S_DONE:  if (start) state_next = S_LEN;
      S_ERROR: if (start) state_next = S_LEN;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      len   <= '0;
      idx   <= '0;
      sum   <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_next;
      if (restart) begin
        sum   <= '0;
        count <= '0;
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end
      if (state == S_LEN && xfer && len_ok) begin
        len <= in_data[ADDR_W:0];
        idx <= '0;
      end
      // idx wraps to 0 only after the final word of a full-depth image, when it is no longer used.
      if (state == S_LOAD && xfer) begin
        mem[idx] <= in_data;
        idx      <= idx + 1'b1;
        sum      <= sum + in_data;
        count    <= count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: reset, good image with and without gaps,
// bad checksum, bad length, reload, start during load and mid-load abort.
module tb_program_loader;

  logic       clk;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [3:0] fetch_addr;
  logic [7:0] fetch_data;
  logic       cpu_reset;
  logic       load_done;
  logic       load_error;
  logic [4:0] byte_count;

  int checks = 0;
  int passes = 0;
  logic [7:0] stim [8];
  logic [7:0] exp_mem [16];

  program_loader dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .fetch_addr(fetch_addr), .fetch_data(fetch_data),
    .cpu_reset(cpu_reset), .load_done(load_done), .load_error(load_error),
    .byte_count(byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present stim[0..n-1]; one byte per cycle, optionally with random idle gaps.
  task automatic send_bytes(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 3);
        for (int k = 0; k < g; k++) begin
          @(negedge clk);
          in_valid = 1'b0;
          in_data  = 8'hEE;
        end
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = stim[i];
      checks++;
      if (in_ready !== 1'b1) $display("FAIL in_ready_for_byte%0d: got %b want 1", i, in_ready);
      else passes++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < 16; a++) begin
      fetch_addr = 4'(a);
      #1;
      checks++;
      if (fetch_data !== exp_mem[a])
        $display("FAIL %s_mem%0d: got %h want %h", tag, a, fetch_data, exp_mem[a]);
      else passes++;
    end
  endtask

  task automatic clear_exp;
    for (int a = 0; a < 16; a++) exp_mem[a] = 8'h00;
  endtask

  task automatic check_flags(input string tag, input logic cr, input logic ld,
                             input logic le, input logic rdy, input logic [4:0] bc);
    checks++;
    if (cpu_reset !== cr) $display("FAIL %s_cpu_reset: got %b want %b", tag, cpu_reset, cr);
    else passes++;
    checks++;
    if (load_done !== ld) $display("FAIL %s_load_done: got %b want %b", tag, load_done, ld);
    else passes++;
    checks++;
    if (load_error !== le) $display("FAIL %s_load_error: got %b want %b", tag, load_error, le);
    else passes++;
    checks++;
    if (in_ready !== rdy) $display("FAIL %s_in_ready: got %b want %b", tag, in_ready, rdy);
    else passes++;
    checks++;
    if (byte_count !== bc) $display("FAIL %s_byte_count: got %0d want %0d", tag, byte_count, bc);
    else passes++;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_flags("reset", 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    clear_exp();
    check_mem("reset");
  endtask

  task automatic load_good_image(input bit gaps);
    stim[0] = 8'h03; stim[1] = 8'hA1; stim[2] = 8'h0C; stim[3] = 8'h5B; stim[4] = 8'hF8;
    pulse_start();
    send_bytes(5, gaps);
  endtask

  task automatic test_good_image(input bit gaps, input string tag);
    load_good_image(gaps);
    check_flags(tag, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3);
    clear_exp();
    exp_mem[0] = 8'hA1; exp_mem[1] = 8'h0C; exp_mem[2] = 8'h5B;
    check_mem(tag);
  endtask

  task automatic test_bad_checksum;
    stim[0] = 8'h02; stim[1] = 8'h11; stim[2] = 8'h22; stim[3] = 8'h00;
    pulse_start();
    send_bytes(4, 1'b0);
    check_flags("badsum", 1'b1, 1'b0, 1'b1, 1'b0, 5'd2);
    clear_exp();
    exp_mem[0] = 8'h11; exp_mem[1] = 8'h22;
    check_mem("badsum");
  endtask

  task automatic test_bad_length;
    pulse_start();
    check_flags("badlen_started", 1'b1, 1'b0, 1'b0, 1'b1, 5'd0);
    stim[0] = 8'h00;
    send_bytes(1, 1'b0);
    check_flags("badlen_zero", 1'b1, 1'b0, 1'b1, 1'b0, 5'd0);
    pulse_start();
    stim[0] = 8'h11;
    send_bytes(1, 1'b0);
    check_flags("badlen_17", 1'b1, 1'b0, 1'b1, 1'b0, 5'd0);
    clear_exp();
    check_mem("badlen");
  endtask

  task automatic test_reload;
    load_good_image(1'b0);
    check_flags("reload_done", 1'b0, 1'b1, 1'b0, 1'b0, 5'd3);
    pulse_start();
    check_flags("reload_restart", 1'b1, 1'b0, 1'b0, 1'b1, 5'd0);
    clear_exp();
    check_mem("reload");
  endtask

  // Continues from LEN left by test_reload; a start mid-load must not disturb it.
  task automatic test_start_in_load;
    stim[0] = 8'h03; stim[1] = 8'hA1;
    send_bytes(2, 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_flags("startload_mid", 1'b1, 1'b0, 1'b0, 1'b1, 5'd1);
    stim[0] = 8'h0C; stim[1] = 8'h5B; stim[2] = 8'hF8;
    send_bytes(3, 1'b0);
    check_flags("startload_end", 1'b0, 1'b1, 1'b0, 1'b0, 5'd3);
    clear_exp();
    exp_mem[0] = 8'hA1; exp_mem[1] = 8'h0C; exp_mem[2] = 8'h5B;
    check_mem("startload");
  endtask

  task automatic test_abort;
    stim[0] = 8'h03; stim[1] = 8'hA1; stim[2] = 8'h0C;
    pulse_start();
    send_bytes(3, 1'b0);
    check_flags("abort_mid", 1'b1, 1'b0, 1'b0, 1'b1, 5'd2);
    fetch_addr = 4'd1;
    #1;
    checks++;
    if (fetch_data !== 8'h0C) $display("FAIL abort_mid_mem1: got %h want 0c", fetch_data);
    else passes++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_flags("abort_after", 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    clear_exp();
    check_mem("abort");
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    fetch_addr = 4'd0;
    test_reset();
    test_good_image(1'b0, "good");
    test_good_image(1'b1, "gaps");
    test_bad_checksum();
    test_bad_length();
    test_reload();
    test_start_in_load();
    test_abort();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
